// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter with a valid/ready input and an internal baud tick counter.
// Frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_byte #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       txd
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int CNT_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_byte: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_byte: STOP_BITS must be 1 or 2");
    end
    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx_byte: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic tick;
    logic frame_end;
    logic accept;

    assign tick      = (baud_q == BIT_LAST);
    assign frame_end = (state_q == S_STOP) && tick && (bit_q == STOP_LAST);
    // A byte already waiting when the last stop bit closes is taken on that
    // same edge, so consecutive frames abut with no idle cycle.
    assign accept    = tx_valid && (ready_q || frame_end);

    always_comb begin
        state_d = state_q;
        baud_d  = tick ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        ready_d = ready_q;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                baud_d  = '0;
                ready_d = 1'b1;
                txd_d   = 1'b1;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    bit_d   = 3'd0;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = 3'd0;
            shift_d = tx_data;
            par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
            txd_d   = 1'b0;
            ready_d = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte: four parameter sets run side by side,
// each compared cycle by cycle against a frame-level model.
module tb_uart_tx_byte;

    localparam int NCFG = 4;
    localparam int CFG_CLK    [NCFG] = '{800, 11, 600, 10};
    localparam int CFG_BAUD   [NCFG] = '{100, 2, 100, 3};
    localparam int CFG_PAR    [NCFG] = '{0, 1, 2, 0};
    localparam int CFG_STOP   [NCFG] = '{1, 1, 2, 2};
    // Hand-computed frame lengths in clocks: N bits * BIT_CYCLES.
    localparam int CFG_LOWLEN [NCFG] = '{80, 55, 72, 33};
    // First byte per set and its hand-derived line pattern (bit i = i-th bit on the wire).
    localparam int CFG_FIRST  [NCFG] = '{32'h55, 32'h07, 32'h07, 32'h00};
    localparam int CFG_PAT    [NCFG] = '{32'h2AA, 32'h40E, 32'hE0E, 32'h600};

    logic clk;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL cfg%0d %s: got %0h expected %0h at t=%0t", cfg, name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Value on the wire during bit j of a frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int j, input int par);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (par != 0 && j == 9) return (par == 1) ? ~^d : ^d;
        return 1'b1;
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int P    = CFG_PAR[gi];
        localparam int S    = CFG_STOP[gi];
        localparam int B    = CFG_CLK[gi] / CFG_BAUD[gi];
        localparam int N    = 9 + ((P != 0) ? 1 : 0) + S;
        localparam int FLEN = N * B;

        logic       rst_n;
        logic       tx_valid;
        logic [7:0] tx_data;
        logic       tx_ready;
        logic       tx_busy;
        logic       txd;

        uart_tx_byte #(
            .CLK_FREQ (CFG_CLK[gi]),
            .BAUD     (CFG_BAUD[gi]),
            .PARITY   (P),
            .STOP_BITS(S)
        ) dut (
            .clk_50m (clk),
            .rst_n   (rst_n),
            .tx_data (tx_data),
            .tx_valid(tx_valid),
            .tx_ready(tx_ready),
            .tx_busy (tx_busy),
            .txd     (txd)
        );

        logic       m_live, m_ready, m_busy, m_txd, in_frame;
        logic [7:0] fbyte;
        int         k, acc_cnt, cyc, acc_cyc, last_gap;

        // Frame-level model: k is the clock index inside the current frame.
        initial begin
            m_live = 1'b0; m_ready = 1'b0; m_busy = 1'b0; m_txd = 1'b1; in_frame = 1'b0;
            fbyte = 8'd0; k = 0; acc_cnt = 0; cyc = 0; acc_cyc = 0; last_gap = 0;
            forever begin
                @(posedge clk);
                cyc++;
                m_live = 1'b1;
                if (!rst_n) begin
                    in_frame = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
                end else if (tx_valid && (m_ready || (in_frame && k == FLEN - 1))) begin
                    fbyte = tx_data; in_frame = 1'b1; k = 0; m_ready = 1'b0; m_busy = 1'b1;
                    last_gap = cyc - acc_cyc; acc_cyc = cyc; acc_cnt++;
                end else if (in_frame) begin
                    if (k == FLEN - 1) begin
                        in_frame = 1'b0; m_ready = 1'b1; m_busy = 1'b0;
                    end else begin
                        k++;
                    end
                end else begin
                    m_ready = 1'b1;
                end
                m_txd = in_frame ? frame_bit(fbyte, k / B, P) : 1'b1;
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                if (m_live) begin
                    chk(gi, "txd", txd, m_txd);
                    chk(gi, "tx_ready", tx_ready, m_ready);
                    chk(gi, "tx_busy", tx_busy, m_busy);
                end
            end
        end

        task automatic send(input logic [7:0] b, input logic keep);
            int start;
            start    = acc_cnt;
            tx_valid = 1'b1;
            tx_data  = b;
            for (int t = 0; t < 4 * FLEN && acc_cnt == start; t++) @(negedge clk);
            chk(gi, "accept", acc_cnt - start, 1);
            if (!keep) tx_valid = 1'b0;
        endtask

        task automatic wait_cycles(input int n);
            for (int t = 0; t < n; t++) @(negedge clk);
        endtask

        task automatic measure(input logic [7:0] b, input int pat);
            int low;
            send(b, 1'b0);
            low = 0;
            for (int t = 0; t < 2 * FLEN && tx_ready !== 1'b1; t++) begin
                if (t % B == B / 2) begin
                    chk(gi, "pin_dut_bit", txd, pat[t / B]);
                    chk(gi, "pin_model_bit", m_txd, pat[t / B]);
                end
                low++;
                @(negedge clk);
            end
            chk(gi, "ready_low_cycles", low, CFG_LOWLEN[gi]);
        endtask

        initial begin
            int start;
            rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'd0;
            wait_cycles(3);
            chk(gi, "reset_ready", tx_ready, 1'b0);
            chk(gi, "reset_txd", txd, 1'b1);
            rst_n = 1'b1;
            measure(8'(CFG_FIRST[gi]), CFG_PAT[gi]);
            wait_cycles(2);

            // Valid held across frames: no idle gap between starts.
            send(8'hA3, 1'b1);
            send(8'h0F, 1'b0);
            chk(gi, "b2b_gap", last_gap, CFG_LOWLEN[gi]);
            send(8'($urandom_range(0, 255)), 1'b1);
            send(8'($urandom_range(0, 255)), 1'b1);
            send(8'($urandom_range(0, 255)), 1'b0);
            chk(gi, "b2b_gap_rand", last_gap, CFG_LOWLEN[gi]);
            wait_cycles(FLEN + 3);

            // Abort mid-frame, then a clean frame from its start bit.
            send(8'($urandom_range(0, 255)), 1'b0);
            wait_cycles(FLEN * 2 / 5);
            rst_n = 1'b0;
            @(negedge clk);
            chk(gi, "abort_txd", txd, 1'b1);
            chk(gi, "abort_busy", tx_busy, 1'b0);
            rst_n = 1'b1;
            send(8'hC3, 1'b0);
            wait_cycles(FLEN + 3);

            // A valid pulse while busy must be ignored.
            start = acc_cnt;
            send(8'($urandom_range(0, 255)), 1'b0);
            wait_cycles(3);
            tx_valid = 1'b1; tx_data = 8'hFF;
            @(negedge clk);
            tx_valid = 1'b0;
            wait_cycles(FLEN + 5);
            chk(gi, "busy_valid_ignored", acc_cnt - start, 1);

            for (int i = 0; i < 4; i++) begin
                wait_cycles($urandom_range(0, 3));
                send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
            tx_valid = 1'b0;
            wait_cycles(2 * FLEN + 4);
            done_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && done_cnt < NCFG; t++) @(negedge clk);
        chk(-1, "all_sets_done", done_cnt, NCFG);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
